// File: rtl/mac_video_timing_gen.sv
// Raster timing generator for a Mac SE style display: a pixel-rate divider
// drives h/v counters, and every visible output is a register decoded from the next position.
module mac_video_timing_gen #(
    parameter int H_ACTIVE = 512,
    parameter int H_FP     = 14,
    parameter int H_SYNC   = 176,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 342,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int CLK_DIV  = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COORD_W  = 10
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               resync,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] x_coord,
    output logic [COORD_W-1:0] y_coord,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject geometries the counters cannot represent or that lack a porch/sync region.
    if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
        $error("H_TOTAL does not fit in COORD_W bits");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
        $error("V_TOTAL does not fit in COORD_W bits");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("porch and sync parameters must be non-zero");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0]   div;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               tick;

    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;
    logic               act_nxt;
    logic               hs_nxt;
    logic               vs_nxt;

    assign tick = enable && (div == DIV_LAST);

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        h_nxt = h + 1'b1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt  = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : !HS_POL;
        vs_nxt  = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : !VS_POL;
    end

    // Parking at the last position makes the first tick after reset/resync land on (0,0).
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div         <= '0;
            h           <= H_LAST;
            v           <= V_LAST;
            pix_ce      <= 1'b0;
            active      <= 1'b0;
            x_coord     <= '0;
            y_coord     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
        end else if (resync) begin
            div         <= '0;
            h           <= H_LAST;
            v           <= V_LAST;
            pix_ce      <= 1'b0;
            active      <= 1'b0;
            x_coord     <= '0;
            y_coord     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
        end else begin
            pix_ce <= tick;
            if (enable) begin
                div <= tick ? '0 : div + 1'b1;
            end
            if (tick) begin
                h           <= h_nxt;
                v           <= v_nxt;
                active      <= act_nxt;
                x_coord     <= act_nxt ? h_nxt : '0;
                y_coord     <= act_nxt ? v_nxt : '0;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
                hsync       <= hs_nxt;
                vsync       <= vs_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mac_video_timing_gen.sv
// Bench for mac_video_timing_gen: four geometries share one stimulus stream and are
// checked every cycle against an arithmetic pixel-count model plus hand-computed points.
module tb_mac_video_timing_gen;

    localparam int NCFG = 4;
    // cfg0 defaults, cfg1 narrow lines / default frame height, cfg2 divided clock
    // with positive hsync, cfg3 tiny 7x6 raster.
    localparam int HA  [NCFG] = '{512, 16, 16, 4};
    localparam int HFP [NCFG] = '{14, 2, 2, 1};
    localparam int HSW [NCFG] = '{176, 4, 4, 1};
    localparam int HBP [NCFG] = '{2, 2, 2, 1};
    localparam int VA  [NCFG] = '{342, 342, 3, 3};
    localparam int VFP [NCFG] = '{1, 1, 1, 1};
    localparam int VSW [NCFG] = '{4, 4, 1, 1};
    localparam int VBP [NCFG] = '{23, 23, 1, 1};
    localparam int DIV [NCFG] = '{1, 1, 4, 1};
    localparam int HPOL[NCFG] = '{0, 0, 1, 0};
    localparam int VPOL[NCFG] = '{0, 0, 0, 0};

    logic clk_in = 1'b0;
    logic reset;
    logic enable;
    logic resync;

    logic       pix_ce     [NCFG];
    logic       hsync      [NCFG];
    logic       vsync      [NCFG];
    logic       active     [NCFG];
    logic       line_start [NCFG];
    logic       frame_start[NCFG];
    logic [9:0] x_coord    [NCFG];
    logic [9:0] y_coord    [NCFG];

    int n_cmp  = 0;
    int n_fail = 0;
    int t      = 0;

    always #5 clk_in = ~clk_in;

    mac_video_timing_gen u_dut0 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .resync(resync),
        .pix_ce(pix_ce[0]), .hsync(hsync[0]), .vsync(vsync[0]), .active(active[0]),
        .x_coord(x_coord[0]), .y_coord(y_coord[0]),
        .line_start(line_start[0]), .frame_start(frame_start[0])
    );

    mac_video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2)
    ) u_dut1 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .resync(resync),
        .pix_ce(pix_ce[1]), .hsync(hsync[1]), .vsync(vsync[1]), .active(active[1]),
        .x_coord(x_coord[1]), .y_coord(y_coord[1]),
        .line_start(line_start[1]), .frame_start(frame_start[1])
    );

    mac_video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .HS_POL(1'b1)
    ) u_dut2 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .resync(resync),
        .pix_ce(pix_ce[2]), .hsync(hsync[2]), .vsync(vsync[2]), .active(active[2]),
        .x_coord(x_coord[2]), .y_coord(y_coord[2]),
        .line_start(line_start[2]), .frame_start(frame_start[2])
    );

    mac_video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut3 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .resync(resync),
        .pix_ce(pix_ce[3]), .hsync(hsync[3]), .vsync(vsync[3]), .active(active[3]),
        .x_coord(x_coord[3]), .y_coord(y_coord[3]),
        .line_start(line_start[3]), .frame_start(frame_start[3])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, got, exp, t);
        end
    endtask

    // Model state: enabled cycles and pixel ticks counted since the last restart.
    int ecnt [NCFG];
    int ntick[NCFG];
    bit ce   [NCFG];

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            ecnt[i]  = 0;
            ntick[i] = 0;
            ce[i]    = 1'b0;
        end
    end

    always @(posedge clk_in or posedge reset) begin
        for (int i = 0; i < NCFG; i++) begin
            if (reset || resync) begin
                ecnt[i]  <= 0;
                ntick[i] <= 0;
                ce[i]    <= 1'b0;
            end else if (enable) begin
                ecnt[i]  <= ecnt[i] + 1;
                ce[i]    <= ((ecnt[i] + 1) % DIV[i]) == 0;
                ntick[i] <= ntick[i] + ((((ecnt[i] + 1) % DIV[i]) == 0) ? 1 : 0);
            end else begin
                ce[i] <= 1'b0;
            end
        end
    end

    // Expected {pix_ce, hsync, vsync, active, line_start, frame_start, x, y}:
    // tick n (1-based) displays raster pixel n-1 in row-major order.
    function automatic logic [25:0] model_out(input int i, input int nt, input bit c);
        int ht, vt, p, h, v;
        bit hp, vp, act, hs_on, vs_on;
        hp = (HPOL[i] != 0);
        vp = (VPOL[i] != 0);
        if (nt == 0) return {1'b0, ~hp, ~vp, 3'b000, 20'd0};
        ht    = HA[i] + HFP[i] + HSW[i] + HBP[i];
        vt    = VA[i] + VFP[i] + VSW[i] + VBP[i];
        p     = nt - 1;
        h     = p % ht;
        v     = (p / ht) % vt;
        act   = (h < HA[i]) && (v < VA[i]);
        hs_on = (h >= HA[i] + HFP[i]) && (h < HA[i] + HFP[i] + HSW[i]);
        vs_on = (v >= VA[i] + VFP[i]) && (v < VA[i] + VFP[i] + VSW[i]);
        return {c, hs_on ? hp : ~hp, vs_on ? vp : ~vp, act, h == 0, (h == 0) && (v == 0),
                10'(act ? h : 0), 10'(act ? v : 0)};
    endfunction

    always @(negedge clk_in) begin
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d_outputs", i),
                  {6'd0, pix_ce[i], hsync[i], vsync[i], active[i], line_start[i],
                   frame_start[i], x_coord[i], y_coord[i]},
                  {6'd0, model_out(i, ntick[i], ce[i])});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
        t += n;
    endtask

    task automatic goto(input int target);
        step(target - t);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        resync = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_active0", {31'd0, active[0]}, 32'd0);
        check("rst_hsync0", {31'd0, hsync[0]}, 32'd1);
        check("rst_hsync2_pos", {31'd0, hsync[2]}, 32'd0);
        check("rst_x0", {22'd0, x_coord[0]}, 32'd0);

        reset  = 1'b0;
        enable = 1'b1;
        t      = 0;

        step(1);
        check("first_fs0", {31'd0, frame_start[0]}, 32'd1);
        check("first_active0", {31'd0, active[0]}, 32'd1);
        check("first_ce0", {31'd0, pix_ce[0]}, 32'd1);
        check("first_active2_div", {31'd0, active[2]}, 32'd0);
        check("first_ce2_div", {31'd0, pix_ce[2]}, 32'd0);
        goto(4);
        check("div4_fs2", {31'd0, frame_start[2]}, 32'd1);
        check("div4_ce2", {31'd0, pix_ce[2]}, 32'd1);
        goto(5);
        check("div4_ce2_gap", {31'd0, pix_ce[2]}, 32'd0);
        check("div4_x2_hold", {22'd0, x_coord[2]}, 32'd0);
        goto(6);
        check("small_hsync3_h5", {31'd0, hsync[3]}, 32'd0);
        goto(7);
        check("small_active3_h6", {31'd0, active[3]}, 32'd0);
        check("small_hsync3_h6", {31'd0, hsync[3]}, 32'd1);
        goto(8);
        check("small_wrap_ls3", {31'd0, line_start[3]}, 32'd1);
        check("small_wrap_y3", {22'd0, y_coord[3]}, 32'd1);
        check("small_wrap_fs3", {31'd0, frame_start[3]}, 32'd0);
        goto(29);
        check("small_vsync3_v4", {31'd0, vsync[3]}, 32'd0);
        goto(42);
        check("small_last_fs3", {31'd0, frame_start[3]}, 32'd0);
        check("small_last_vsync3", {31'd0, vsync[3]}, 32'd1);
        goto(43);
        check("small_frame2_fs3", {31'd0, frame_start[3]}, 32'd1);
        goto(75);
        check("div4_hsync2_h17", {31'd0, hsync[2]}, 32'd0);
        goto(76);
        check("div4_hsync2_h18", {31'd0, hsync[2]}, 32'd1);

        goto(101);
        check("pre_stall_x0", {22'd0, x_coord[0]}, 32'd100);
        enable = 1'b0;
        step(10);
        check("stall_x0", {22'd0, x_coord[0]}, 32'd100);
        check("stall_ce0", {31'd0, pix_ce[0]}, 32'd0);
        enable = 1'b1;
        step(1);
        check("resume_x0", {22'd0, x_coord[0]}, 32'd101);
        check("resume_ce0", {31'd0, pix_ce[0]}, 32'd1);

        // From here cfg0/cfg1 show pixel t-11.
        goto(522);
        check("h511_x0", {22'd0, x_coord[0]}, 32'd511);
        goto(523);
        check("h512_active0", {31'd0, active[0]}, 32'd0);
        check("h512_x0", {22'd0, x_coord[0]}, 32'd0);
        goto(536);
        check("h525_hsync0", {31'd0, hsync[0]}, 32'd1);
        goto(537);
        check("h526_hsync0", {31'd0, hsync[0]}, 32'd0);
        goto(712);
        check("h701_hsync0", {31'd0, hsync[0]}, 32'd0);
        goto(713);
        check("h702_hsync0", {31'd0, hsync[0]}, 32'd1);

        goto(8195);
        check("v341_y1", {22'd0, y_coord[1]}, 32'd341);
        goto(8242);
        check("v342_vsync1", {31'd0, vsync[1]}, 32'd1);
        goto(8243);
        check("v343_vsync1", {31'd0, vsync[1]}, 32'd0);
        check("v343_active1", {31'd0, active[1]}, 32'd0);
        goto(8338);
        check("v346_vsync1", {31'd0, vsync[1]}, 32'd0);
        goto(8339);
        check("v347_vsync1", {31'd0, vsync[1]}, 32'd1);

        goto(8759);
        check("pre_resync_x0", {22'd0, x_coord[0]}, 32'd300);
        resync = 1'b1;
        step(1);
        resync = 1'b0;
        check("resync_active0", {31'd0, active[0]}, 32'd0);
        check("resync_ce0", {31'd0, pix_ce[0]}, 32'd0);
        check("resync_hsync0", {31'd0, hsync[0]}, 32'd1);
        step(1);
        check("post_resync_fs0", {31'd0, frame_start[0]}, 32'd1);
        check("post_resync_x0", {22'd0, x_coord[0]}, 32'd0);
        check("post_resync_active0", {31'd0, active[0]}, 32'd1);

        step(50);
        #2 reset = 1'b1;
        #1;
        check("async_rst_active0", {31'd0, active[0]}, 32'd0);
        check("async_rst_x0", {22'd0, x_coord[0]}, 32'd0);
        check("async_rst_ce0", {31'd0, pix_ce[0]}, 32'd0);
        check("async_rst_hsync2", {31'd0, hsync[2]}, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        step(1);
        check("post_rst_fs0", {31'd0, frame_start[0]}, 32'd1);
        check("post_rst_active0", {31'd0, active[0]}, 32'd1);

        step(200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
